// File: rtl/registers_bank_reader.sv
// Snapshots the flattened register-bank debug bus on start and streams it out byte by byte.
// Optional leading 8'hA5 header byte is enabled with REGISTERS_BANK_READER_HEADER_EN.
module registers_bank_reader #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int REGISTERS_SIZE      = 32,
    parameter int BYTE_SIZE           = 8
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic                                          i_flush,
    input  logic                                          i_start,
    input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
    input  logic                                          i_ready,
    output logic [BYTE_SIZE-1:0]                          o_data,
    output logic                                          o_valid,
    output logic                                          o_busy,
    output logic                                          o_done
);

    localparam int BUS_W = REGISTERS_BANK_SIZE * REGISTERS_SIZE;
    localparam int BPR   = REGISTERS_SIZE / BYTE_SIZE;
    localparam int N     = REGISTERS_BANK_SIZE * BPR;
    localparam int CW    = $clog2(N + 1);
`ifdef REGISTERS_BANK_READER_HEADER_EN
    localparam int TOTAL = N + 1;
`else
    localparam int TOTAL = N;
`endif
    localparam logic [CW-1:0] LAST_POS = CW'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [BUS_W-1:0]     snapshot_q, snapshot_d;
    logic [CW-1:0]        count_q, count_d;
    logic [BYTE_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Stream position to byte: header (if any) at position 0, then R0 LSB upward.
    function automatic logic [BYTE_SIZE-1:0] pickByte(input logic [BUS_W-1:0] src,
                                                      input logic [CW-1:0]    pos);
        int unsigned dataIdx;
`ifdef REGISTERS_BANK_READER_HEADER_EN
        if (pos == '0) begin
            return BYTE_SIZE'(8'hA5);
        end
        dataIdx = 32'(pos) - 32'd1;
`else
        dataIdx = 32'(pos);
`endif
        return BYTE_SIZE'(src >> (dataIdx * 32'(BYTE_SIZE)));
    endfunction

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            snapshot_q <= '0;
            count_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            snapshot_q <= snapshot_d;
            count_q    <= count_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Flush overrides everything; the first byte comes straight from the live bus at the start edge.
    always_comb begin
        state_d    = state_q;
        snapshot_d = snapshot_q;
        count_d    = count_q;
        data_d     = data_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (i_flush) begin
            state_d = IDLE;
            count_d = '0;
            data_d  = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        snapshot_d = i_bus_debug;
                        count_d    = '0;
                        data_d     = pickByte(i_bus_debug, '0);
                        valid_d    = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = SEND;
                    end
                end
                SEND: begin
                    if (valid_q && i_ready) begin
                        if (count_q == LAST_POS) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            count_d = count_q + 1'b1;
                            data_d  = pickByte(snapshot_q, count_q + 1'b1);
                        end
                    end
                end
                DONE: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_registers_bank_reader.sv
// Directed bench for registers_bank_reader with a 4x32-bit bank.
// Define REGISTERS_BANK_READER_HEADER_EN for both files to exercise the header byte.
module tb_registers_bank_reader;

    localparam int BANK = 4;
    localparam int RSZ  = 32;
`ifdef REGISTERS_BANK_READER_HEADER_EN
    localparam int TOTAL = 17;
`else
    localparam int TOTAL = 16;
`endif

    logic                i_clk = 1'b0;
    logic                i_reset;
    logic                i_flush;
    logic                i_start;
    logic                i_ready;
    logic [BANK*RSZ-1:0] busDebug;
    logic [7:0]          o_data;
    logic                o_valid;
    logic                o_busy;
    logic                o_done;

    int checkCount = 0;
    int errorCount = 0;
    int seedDummy;

    logic [7:0] dataBytes [16] = '{8'h00, 8'h00, 8'h00, 8'h00,
                                   8'h44, 8'h33, 8'h22, 8'h11,
                                   8'hEF, 8'hBE, 8'hAD, 8'hDE,
                                   8'h0D, 8'hF0, 8'hFE, 8'hCA};

    registers_bank_reader #(
        .REGISTERS_BANK_SIZE(BANK),
        .REGISTERS_SIZE     (RSZ),
        .BYTE_SIZE          (8)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_flush    (i_flush),
        .i_start    (i_start),
        .i_bus_debug(busDebug),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] expByte(input int pos);
`ifdef REGISTERS_BANK_READER_HEADER_EN
        if (pos == 0) return 8'hA5;
        return dataBytes[pos-1];
`else
        return dataBytes[pos];
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; leaves us at the falling edge after the start edge.
    task automatic applyStimulus();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        checkOutput("startValid", 32'(o_valid), 32'd1);
        checkOutput("startBusy", 32'(o_busy), 32'd1);
    endtask

    task automatic collectDump(input bit randomReady, input int modifyAt, input int startAt);
        int idx = 0;
        int cyc = 0;
        int doneEarly = 0;
        int extra = 0;
        bit held = 1'b0;
        logic [7:0] heldData = '0;
        bit rdy;
        while (idx < TOTAL && cyc < 200) begin
            if (cyc == modifyAt) busDebug[63:32] = 32'hFFFFFFFF;
            i_start = (cyc == startAt);
            if (held) begin
                checkOutput("holdValid", 32'(o_valid), 32'd1);
                checkOutput("holdData", 32'(o_data), 32'(heldData));
            end
            if (o_done) doneEarly++;
            rdy = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            i_ready = rdy;
            held = 1'b0;
            if (o_valid && rdy) begin
                checkOutput($sformatf("byte%0d", idx), 32'(o_data), 32'(expByte(idx)));
                idx++;
            end else if (o_valid) begin
                held = 1'b1;
                heldData = o_data;
            end
            cyc++;
            @(negedge i_clk);
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        checkOutput("handshakes", 32'(idx), 32'(TOTAL));
        if (!randomReady) checkOutput("cycles", 32'(cyc), 32'(TOTAL));
        checkOutput("doneEarly", 32'(doneEarly), 32'd0);
        checkOutput("donePulse", 32'(o_done), 32'd1);
        checkOutput("validAtDone", 32'(o_valid), 32'd0);
        checkOutput("busyAtDone", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        checkOutput("doneFall", 32'(o_done), 32'd0);
        checkOutput("busyFall", 32'(o_busy), 32'd0);
        repeat (4) begin
            if (o_valid || o_busy || o_done) extra++;
            @(negedge i_clk);
        end
        checkOutput("idleAfter", 32'(extra), 32'd0);
    endtask

    // Accept bytes 0..5, then abort with flush or asynchronous reset.
    task automatic abortRun(input bit useReset);
        int stray = 0;
        i_ready = 1'b1;
        applyStimulus();
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("abortByte%0d", i), 32'(o_data), 32'(expByte(i)));
            @(negedge i_clk);
        end
        if (useReset) begin
            i_reset = 1'b0;
            #1;
            checkOutput("rstValid", 32'(o_valid), 32'd0);
            checkOutput("rstBusy", 32'(o_busy), 32'd0);
            checkOutput("rstData", 32'(o_data), 32'd0);
            @(negedge i_clk);
            i_reset = 1'b1;
        end else begin
            i_flush = 1'b1;
            @(negedge i_clk);
            i_flush = 1'b0;
            checkOutput("flushValid", 32'(o_valid), 32'd0);
            checkOutput("flushBusy", 32'(o_busy), 32'd0);
            checkOutput("flushDone", 32'(o_done), 32'd0);
        end
        repeat (3) begin
            if (o_done || o_valid) stray++;
            @(negedge i_clk);
        end
        checkOutput("abortQuiet", 32'(stray), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        i_reset  = 1'b0;
        i_flush  = 1'b0;
        i_start  = 1'b0;
        i_ready  = 1'b0;
        busDebug = {32'hCAFEF00D, 32'hDEADBEEF, 32'h11223344, 32'h00000000};
        #12;
        checkOutput("rstValid0", 32'(o_valid), 32'd0);
        checkOutput("rstBusy0", 32'(o_busy), 32'd0);
        checkOutput("rstDone0", 32'(o_done), 32'd0);
        checkOutput("rstData0", 32'(o_data), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);

        $display("[TB] full dump");
        i_ready = 1'b1;
        applyStimulus();
        collectDump(1'b0, -1, -1);

        $display("[TB] backpressure");
        seedDummy = $urandom(616563);
        applyStimulus();
        collectDump(1'b1, -1, -1);

        $display("[TB] snapshot isolation");
        applyStimulus();
        collectDump(1'b0, 1, -1);
        busDebug[63:32] = 32'h11223344;

        $display("[TB] start ignored during send");
        applyStimulus();
        collectDump(1'b0, -1, 3);

        $display("[TB] flush abort");
        abortRun(1'b0);
        applyStimulus();
        collectDump(1'b0, -1, -1);

        $display("[TB] reset abort");
        abortRun(1'b1);
        applyStimulus();
        collectDump(1'b0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/registers_bank_reader.md
Name: registers_bank_reader

Overview:
- Reads the flattened debug snapshot of the ID-stage `registers_bank` and streams it out byte by byte over a valid/ready handshake.
- The consumer is the debug UART transmitter path.
- It is the read/export end of the register bank debug interface: the bank writes the registers, this block reads them all out on request.
- It snapshots the whole bus on start, so the bank may keep changing during the transfer.

Parameters:
- REGISTERS_BANK_SIZE, 32, number of registers in the debug bus.
- REGISTERS_SIZE, 32, width of each register in bits; must be a multiple of BYTE_SIZE.
- BYTE_SIZE, 8, width of the output data word.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_flush  in  1  synchronous abort; returns to IDLE without o_done.
- i_start  in  1  dump request, sampled only in IDLE.
- i_bus_debug  in  REGISTERS_BANK_SIZE*REGISTERS_SIZE  flattened bank contents; R0 in bits [REGISTERS_SIZE-1:0].
- i_ready  in  1  consumer accepts o_data when high together with o_valid.
- o_data  out  BYTE_SIZE  current output byte.
- o_valid  out  1  o_data is valid.
- o_busy  out  1  high from the start-accept edge until the return to IDLE.
- o_done  out  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State goes to IDLE.
  - o_data=0, o_valid=0, o_busy=0, o_done=0.
  - Snapshot register and byte counter cleared.
  - Reset asserted mid-transfer aborts the transfer immediately; nothing resumes after release.
- Constants:
  - BPR = REGISTERS_SIZE/BYTE_SIZE bytes per register.
  - N = REGISTERS_BANK_SIZE*BPR total bytes.
  - Byte counter width is $clog2(N+1).
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - If i_start=1 at edge k, capture i_bus_debug into the snapshot and clear the counter to 0.
  - At the same edge k, set o_valid=1, o_data=byte 0, o_busy=1, and go to SEND.
  - This gives one-cycle latency from i_start to the first valid byte.
- Byte order:
  - Register index ascending (R0 first).
  - Within each register, least significant byte first.
  - Byte i is snapshot[i*BYTE_SIZE +: BYTE_SIZE].
- SEND:
  - A handshake occurs at an edge where o_valid=1 and i_ready=1.
  - While o_valid=1 and i_ready=0, o_data and o_valid hold stable. No byte may be dropped or changed.
  - On a handshake with counter < N-1: counter increments and o_data shows the next byte at the same edge, so back-to-back transfers run at one byte per cycle.
  - On a handshake with counter = N-1: o_valid goes to 0, o_done goes to 1, and the FSM moves to DONE.
- DONE:
  - Lasts exactly one cycle.
  - At the next edge: o_done=0, o_busy=0, and the FSM returns to IDLE.
  - A start request can be accepted on the edge after that.
- i_start while in SEND or DONE is ignored. It is not queued.
- i_flush=1 at any edge:
  - FSM goes to IDLE; o_valid, o_busy and o_done go to 0; the counter clears.
  - i_flush has priority over i_start and over any handshake at the same edge.
- i_bus_debug changes after the start edge have no effect on the bytes sent.

Optional Feature:
- Macro: REGISTERS_BANK_READER_HEADER_EN.
- When defined:
  - A header byte 8'hA5 is emitted as the first byte (counter position 0), followed by the N data bytes.
  - The transfer is N+1 handshakes in total; o_done follows the last data byte.
  - The counter range extends to N.
- When undefined: no header is emitted, the transfer is exactly N bytes, and the counter range is 0..N-1.

Test Plan:
- Setup for all scenarios: bench parameters REGISTERS_BANK_SIZE=4, REGISTERS_SIZE=32; i_bus_debug with R0=0, R1=32'h11223344, R2=32'hDEADBEEF, R3=32'hCAFEF00D.
- Full dump, i_ready held at 1, pulse i_start:
  - Bytes 00 00 00 00 44 33 22 11 EF BE AD DE 0D F0 FE CA are sent on 16 consecutive cycles.
  - o_done pulses for exactly 1 cycle; o_busy falls one cycle after o_done rises.
- Backpressure, i_ready random (seed 616563):
  - The same 16-byte sequence is received in order with no duplicates.
  - o_data is stable whenever o_valid=1 and i_ready=0.
- Snapshot isolation: change R1 to 32'hFFFFFFFF two cycles after the start edge; bytes 4..7 are still 44 33 22 11.
- Abort handling:
  - Assert i_flush after byte 5: o_valid=0 and o_busy=0 on the next cycle, no o_done pulse; a new i_start then restarts from byte 00.
  - Repeat the abort with i_reset=0 after byte 5: outputs go to 0 asynchronously with the same result.
- Ignored start: pulse i_start during SEND; the transfer is still exactly 16 bytes and no second dump follows.
- Header feature (REGISTERS_BANK_READER_HEADER_EN defined): the first byte is A5, followed by the 16 data bytes, 17 handshakes in total.
